// File: rtl/iob_native2iob_bridge.sv
// iob_native2iob_bridge: PicoRV32-style native port to N IOb channels.
// Routes by address MSBs and remaps fetches to the boot slave in boot mode.
// It acks writes internally and aborts hung accesses on a timeout.
// Ports:
//   clk_i, rst_i, cke_i            clock, sync reset, clock enable
//   boot_i                         boot mode (fetches -> BOOT_SLAVE)
//   n_valid_i..n_wstrb_i           native request (wstrb 0 = read)
//   n_rdata_o, n_ready_o, err_o    native completion (1-cycle pulse)
//   iob_avalid_o                   per-slave request (one-hot or 0)
//   iob_addr/wdata/wstrb_o         shared latched request fields
//   iob_ready_i, iob_rvalid_i      per-slave accept / read valid
//   iob_rdata_i                    per-slave read data, packed by index
module iob_native2iob_bridge #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int N_SLAVES   = 2,
   parameter int SEL_W      = 1,
   parameter int BOOT_SLAVE = 0,
   parameter int TIMEOUT_W  = 8,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF),
   localparam int WSTRB_W   = DATA_W / 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       cke_i,
   input  logic                       boot_i,
   input  logic                       n_valid_i,
   input  logic                       n_instr_i,
   input  logic [ADDR_W-1:0]          n_addr_i,
   input  logic [DATA_W-1:0]          n_wdata_i,
   input  logic [WSTRB_W-1:0]         n_wstrb_i,
   output logic [DATA_W-1:0]          n_rdata_o,
   output logic                       n_ready_o,
   output logic                       err_o,
   output logic [N_SLAVES-1:0]        iob_avalid_o,
   output logic [ADDR_W-1:0]          iob_addr_o,
   output logic [DATA_W-1:0]          iob_wdata_o,
   output logic [WSTRB_W-1:0]         iob_wstrb_o,
   input  logic [N_SLAVES-1:0]        iob_ready_i,
   input  logic [N_SLAVES-1:0]        iob_rvalid_i,
   input  logic [N_SLAVES*DATA_W-1:0] iob_rdata_i
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      ACK
   } state_t;

   // Last timer value before the limit: the next waiting
   // cycle would reach 2**TIMEOUT_W-1, so abort on it.
   localparam logic [TIMEOUT_W-1:0] T_LAST =
      TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

   state_t               state_q;
   logic [SEL_W-1:0]     sel_q;
   logic [TIMEOUT_W-1:0] timer_q;

   logic [SEL_W-1:0]     sel_n;
   logic                 sel_ok;
   logic [N_SLAVES-1:0]  onehot_n;
   logic                 rdy_sel;
   logic                 rvl_sel;
   logic [DATA_W-1:0]    rdata_sel;
   logic                 to_hit;

   // Decode the incoming request and mux the latched
   // slave's handshake; other slaves are never looked at.
   always_comb begin
      sel_n = (boot_i & n_instr_i) ? SEL_W'(BOOT_SLAVE)
                                   : n_addr_i[ADDR_W-1 -: SEL_W];
      sel_ok    = 1'b0;
      onehot_n  = '0;
      rdy_sel   = 1'b0;
      rvl_sel   = 1'b0;
      rdata_sel = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (sel_n == SEL_W'(k)) begin
            sel_ok      = 1'b1;
            onehot_n[k] = 1'b1;
         end
         if (sel_q == SEL_W'(k)) begin
            rdy_sel   = iob_ready_i[k];
            rvl_sel   = iob_rvalid_i[k];
            rdata_sel = iob_rdata_i[k*DATA_W +: DATA_W];
         end
      end
   end

   assign to_hit = (timer_q == T_LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         timer_q      <= '0;
         n_ready_o    <= 1'b0;
         err_o        <= 1'b0;
         n_rdata_o    <= '0;
         iob_avalid_o <= '0;
         iob_addr_o   <= '0;
         iob_wdata_o  <= '0;
         iob_wstrb_o  <= '0;
      end else if (cke_i) begin
         unique case (state_q)
            IDLE: begin
               n_ready_o <= 1'b0;
               err_o     <= 1'b0;
               if (n_valid_i) begin
                  iob_addr_o  <= n_addr_i;
                  iob_wdata_o <= n_wdata_i;
                  iob_wstrb_o <= n_wstrb_i;
                  sel_q       <= sel_n;
                  timer_q     <= '0;
                  if (sel_ok) begin
                     iob_avalid_o <= onehot_n;
                     state_q      <= REQ;
                  end else begin
                     // no such slave: error ack, no bus cycle
                     state_q   <= ACK;
                     n_ready_o <= 1'b1;
                     err_o     <= 1'b1;
                     n_rdata_o <= ERR_DATA;
                  end
               end
            end
            REQ: begin
               timer_q <= timer_q + TIMEOUT_W'(1);
               if (rdy_sel) begin
                  iob_avalid_o <= '0;
                  if (|iob_wstrb_o) begin
                     // writes are acked locally on accept
                     state_q   <= ACK;
                     n_ready_o <= 1'b1;
                     n_rdata_o <= '0;
                  end else begin
                     state_q <= RESP;
                  end
               end else if (to_hit) begin
                  iob_avalid_o <= '0;
                  state_q      <= ACK;
                  n_ready_o    <= 1'b1;
                  err_o        <= 1'b1;
                  n_rdata_o    <= ERR_DATA;
               end
            end
            RESP: begin
               timer_q <= timer_q + TIMEOUT_W'(1);
               if (rvl_sel) begin
                  state_q   <= ACK;
                  n_ready_o <= 1'b1;
                  n_rdata_o <= rdata_sel;
               end else if (to_hit) begin
                  state_q   <= ACK;
                  n_ready_o <= 1'b1;
                  err_o     <= 1'b1;
                  n_rdata_o <= ERR_DATA;
               end
            end
            ACK: begin
               n_ready_o <= 1'b0;
               err_o     <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iob_native2iob_bridge.sv
// tb_iob_native2iob_bridge: directed bench, scoreboard queue
// plus a negedge monitor checking every native completion.
module tb_iob_native2iob_bridge;

   localparam logic [31:0] S0D  = 32'h0A0A_1111;
   localparam logic [31:0] S1D  = 32'h0B0B_2222;
   localparam logic [31:0] BAD  = 32'hBAD0_BAD0;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, cke, boot;
   logic        n_valid, n_instr;
   logic [31:0] n_addr, n_wdata, n_rdata;
   logic [3:0]  n_wstrb, iob_wstrb;
   logic        n_ready, err;
   logic [1:0]  av, iob_ready, iob_rvalid;
   logic [31:0] iob_addr, iob_wdata;
   logic [63:0] iob_rdata;

   logic        n3_valid;
   logic [31:0] n3_addr, n3_rdata, iob3_addr, iob3_wdata;
   logic [3:0]  iob3_wstrb;
   logic        n3_ready, err3;
   logic [2:0]  av3;

   iob_native2iob_bridge #(
      .N_SLAVES(2), .SEL_W(1), .BOOT_SLAVE(0), .TIMEOUT_W(4)
   ) dut (
      .clk_i(clk), .rst_i(rst), .cke_i(cke), .boot_i(boot),
      .n_valid_i(n_valid), .n_instr_i(n_instr), .n_addr_i(n_addr),
      .n_wdata_i(n_wdata), .n_wstrb_i(n_wstrb), .n_rdata_o(n_rdata),
      .n_ready_o(n_ready), .err_o(err), .iob_avalid_o(av),
      .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata),
      .iob_wstrb_o(iob_wstrb), .iob_ready_i(iob_ready),
      .iob_rvalid_i(iob_rvalid), .iob_rdata_i(iob_rdata)
   );

   iob_native2iob_bridge #(
      .N_SLAVES(3), .SEL_W(2), .BOOT_SLAVE(0), .TIMEOUT_W(4)
   ) dut3 (
      .clk_i(clk), .rst_i(rst), .cke_i(cke), .boot_i(1'b0),
      .n_valid_i(n3_valid), .n_instr_i(1'b0), .n_addr_i(n3_addr),
      .n_wdata_i(32'h0), .n_wstrb_i(4'h0), .n_rdata_o(n3_rdata),
      .n_ready_o(n3_ready), .err_o(err3), .iob_avalid_o(av3),
      .iob_addr_o(iob3_addr), .iob_wdata_o(iob3_wdata),
      .iob_wstrb_o(iob3_wstrb), .iob_ready_i(3'b111),
      .iob_rvalid_i(3'b111), .iob_rdata_i({3{BAD}})
   );

   typedef struct {
      string       nm;
      logic [31:0] d;
      logic        e;
      int          lat;
      int          t0;
   } exp_t;

   exp_t q[$];
   exp_t q3[$];
   exp_t me, me3;
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm,
                               input logic [127:0] act,
                               input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endfunction

   // scoreboard monitors: one per DUT
   always @(negedge clk) begin
      if (n_ready === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_ready got=1 want=no pending request");
         end else begin
            me = q.pop_front();
            chk({me.nm, "_err"}, 128'(err), 128'(me.e));
            chk({me.nm, "_rdata"}, 128'(n_rdata), 128'(me.d));
            if (me.lat >= 0)
               chk({me.nm, "_lat"}, 128'(cyc - me.t0), 128'(me.lat));
         end
      end
   end

   always @(negedge clk) begin
      if (n3_ready === 1'b1) begin
         if (q3.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_ready3 got=1 want=no pending request");
         end else begin
            me3 = q3.pop_front();
            chk({me3.nm, "_err"}, 128'(err3), 128'(me3.e));
            chk({me3.nm, "_rdata"}, 128'(n3_rdata), 128'(me3.d));
         end
      end
   end

   // One native transaction on dut with a scripted slave:
   // rw = wait cycles before ready (-1 never), vw = cycles
   // between accept and rvalid. noise drives handshakes that
   // must be ignored (other slave always, rvalid during REQ).
   task automatic txn(input string nm,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic ins,
                      input logic bt, input int rw, input int vw,
                      input logic [1:0] xav, input int xavc,
                      input logic [31:0] xd, input logic xe,
                      input int xlat, input logic noise);
      exp_t e;
      int   avc, rdy_c, badav;
      logic fin;
      avc = 0; rdy_c = -1; badav = 0; fin = 1'b0;
      @(negedge clk);
      e.nm = nm; e.d = xd; e.e = xe; e.lat = xlat; e.t0 = cyc;
      q.push_back(e);
      n_valid = 1'b1; n_instr = ins; boot = bt;
      n_addr = a; n_wdata = wd; n_wstrb = ws;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         iob_ready  = noise ? ~xav : 2'b00;
         iob_rvalid = noise ? ~xav : 2'b00;
         iob_rdata  = {S1D, S0D};
         if (n_ready === 1'b1) begin
            fin = 1'b1;
            break;
         end
         if (av != 2'b00) begin
            avc++;
            if (av !== xav) badav++;
            if (avc == 1)
               chk({nm, "_bus"}, 128'({iob_addr, iob_wdata, iob_wstrb}),
                   128'({a, wd, ws}));
            if (avc == rw + 1) begin
               iob_ready = iob_ready | xav;
               rdy_c = c;
            end else if (noise) begin
               iob_rvalid = iob_rvalid | xav;
               iob_rdata  = {BAD, BAD};
            end
         end else if (rdy_c >= 0 && ws == 4'h0 &&
                      c == rdy_c + 1 + vw) begin
            iob_rvalid = iob_rvalid | xav;
         end
      end
      n_valid = 1'b0;
      iob_ready = 2'b00;
      iob_rvalid = 2'b00;
      chk({nm, "_done"}, 128'(fin), 128'(1'b1));
      chk({nm, "_avcycles"}, 128'(avc), 128'(xavc));
      chk({nm, "_avonehot"}, 128'(badav), 128'(0));
   endtask

   initial begin
      exp_t e3;
      int   nr, nav, bad, bad3, lat3;
      logic fin;
      rst = 1'b1; cke = 1'b1; boot = 1'b0;
      n_valid = 1'b0; n_instr = 1'b0; n_addr = '0;
      n_wdata = '0; n_wstrb = '0;
      iob_ready = '0; iob_rvalid = '0; iob_rdata = '0;
      n3_valid = 1'b0; n3_addr = '0;
      repeat (3) @(negedge clk);
      chk("reset_state", 128'({n_ready, err, n_rdata, av, iob_addr,
                               iob_wdata, iob_wstrb}), 128'(0));
      chk("reset_state3", 128'({n3_ready, err3, n3_rdata, av3, iob3_addr,
                                iob3_wdata, iob3_wstrb}), 128'(0));
      rst = 1'b0;

      txn("wr_s0", 32'h0000_0010, 32'hA5A5_5A5A, 4'hF, 0, 0,
          0, 0, 2'b01, 1, 32'h0, 0, 2, 0);
      txn("rd_s1", 32'h8000_0004, 32'h0, 4'h0, 0, 0,
          2, 0, 2'b10, 3, S1D, 0, 5, 1);
      txn("rd_min", 32'h0000_0008, 32'h0, 4'h0, 0, 0,
          0, 0, 2'b01, 1, S0D, 0, 3, 0);
      txn("rd_wait", 32'h8000_0000, 32'h0, 4'h0, 0, 0,
          0, 2, 2'b10, 1, S1D, 0, 5, 1);
      txn("boot_fetch", 32'h8000_0000, 32'h0, 4'h0, 1, 1,
          0, 0, 2'b01, 1, S0D, 0, 3, 0);
      txn("noboot_fetch", 32'h8000_0000, 32'h0, 4'h0, 1, 0,
          0, 0, 2'b10, 1, S1D, 0, 3, 0);
      txn("boot_data", 32'h8000_0000, 32'h0, 4'h0, 0, 1,
          0, 0, 2'b10, 1, S1D, 0, 3, 0);
      txn("wr_s1_strb", 32'h8000_0020, 32'hCAFE_F00D, 4'h3, 0, 0,
          1, 0, 2'b10, 2, 32'h0, 0, 3, 1);
      txn("timeout", 32'h0000_0040, 32'h0, 4'h0, 0, 0,
          -1, 0, 2'b01, 15, ERRD, 1, 16, 1);

      nr = 0; nav = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         iob_ready = 2'b01; iob_rvalid = 2'b01;
         if (n_ready === 1'b1) nr++;
         if (av != 2'b00) nav++;
      end
      @(negedge clk);
      iob_ready = 2'b00; iob_rvalid = 2'b00;
      if (n_ready === 1'b1) nr++;
      chk("late_ready_no_ack", 128'(nr), 128'(0));
      chk("late_ready_no_av", 128'(nav), 128'(0));

      @(negedge clk);
      e3.nm = "decode"; e3.d = ERRD; e3.e = 1'b1;
      e3.lat = -1; e3.t0 = cyc;
      q3.push_back(e3);
      n3_valid = 1'b1; n3_addr = 32'hC000_0000;
      fin = 1'b0; bad3 = 0; lat3 = 99;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (av3 != 3'b000) bad3++;
         if (n3_ready === 1'b1) begin
            fin = 1'b1;
            lat3 = cyc - e3.t0;
            break;
         end
      end
      n3_valid = 1'b0;
      chk("decode_done", 128'(fin), 128'(1'b1));
      chk("decode_no_av", 128'(bad3), 128'(0));
      chk("decode_lat_le2", 128'(lat3 <= 2), 128'(1'b1));

      @(negedge clk);
      me.nm = "cke_wr"; me.d = 32'h0; me.e = 1'b0;
      me.lat = -1; me.t0 = cyc;
      q.push_back(me);
      n_valid = 1'b1; n_instr = 1'b0; boot = 1'b0;
      n_addr = 32'h0000_0010; n_wdata = 32'h1234_5678; n_wstrb = 4'hF;
      @(negedge clk);
      chk("cke_pre_av", 128'(av), 128'(2'b01));
      cke = 1'b0;
      iob_ready = 2'b01;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (av !== 2'b01 || n_ready !== 1'b0) bad++;
      end
      chk("cke_frozen", 128'(bad), 128'(0));
      cke = 1'b1;
      @(negedge clk);
      iob_ready = 2'b00;
      n_valid = 1'b0;
      chk("cke_resume_ready", 128'(n_ready), 128'(1'b1));
      chk("cke_resume_av", 128'(av), 128'(2'b00));
      @(negedge clk);

      n_valid = 1'b1; n_addr = 32'h8000_0000;
      n_wstrb = 4'h0; n_instr = 1'b0;
      @(negedge clk);
      chk("rst_req_av", 128'(av), 128'(2'b10));
      iob_ready = 2'b10;
      @(negedge clk);
      iob_ready = 2'b00;
      n_valid = 1'b0;
      rst = 1'b1;
      cke = 1'b0;
      @(negedge clk);
      chk("rst_mid_outputs", 128'({n_ready, err, n_rdata, av, iob_addr,
                                   iob_wdata, iob_wstrb}), 128'(0));
      rst = 1'b0;
      cke = 1'b1;
      iob_rvalid = 2'b10;
      iob_rdata = {S1D, S0D};
      @(negedge clk);
      iob_rvalid = 2'b00;
      chk("rst_no_ready", 128'(n_ready), 128'(0));
      @(negedge clk);
      chk("rst_idle_av", 128'(av), 128'(0));

      repeat (2) @(negedge clk);
      chk("pending_empty", 128'(q.size() + q3.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
